seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Multiplexed, time-scanned driver for a NUM_DIGITS common-select 7-segment display. It is the parametrised successor to the single-digit hex decoder and sits between the game/score logic and the board display pins. It takes a packed multi-digit hex value and cycles through the digit selects at a programmable refresh rate, with anti-ghosting gaps. Values update tear-free at frame boundaries, and it reports frame completion.

## Interface
- NUM_DIGITS, 4: digits driven; 1..8
- REFRESH_DIV, 25000: clocks each digit is driven per slot; ≥2
- GAP_CYCLES, 2: all-off clocks between slots; ≥1
- SEG_ACTIVE_LOW, 0: 1 = segment outputs are active-low
- DIG_ACTIVE_LOW, 1: 1 = digit selects are active-low

- i_clk  in  1  system clock; the block's only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_value  in  4*NUM_DIGITS  packed nibbles; digit k = bits [4k+3:4k]; digit 0 is rightmost
- i_load  in  1  capture i_value this cycle
- i_enable  in  1  0 = display dark, scan held
- o_segments  out  7  registered segments: bit6 = a … bit0 = g
- o_digit_en  out  NUM_DIGITS  registered one-hot digit select (at most one active)
- o_frame_done  out  1  one-cycle pulse when the last slot's gap ends

## Operation
- Reset values:
  - all outputs inactive: o_segments = all-off (polarity-adjusted), o_digit_en = all-off, o_frame_done = 0
  - state OFF; counters, digit index, pending flag, shadow and display registers all 0
- State machine:
  - OFF: outputs inactive. i_enable=1 → DRIVE with digit index 0 and slot counter 0.
  - DRIVE: select digit[idx] and drive its decoded segments. After REFRESH_DIV cycles → GAP.
  - GAP: outputs inactive for GAP_CYCLES cycles. Then:
    - if idx < NUM_DIGITS-1: idx+1 → DRIVE
    - else: frame boundary. Pulse o_frame_done, set idx=0 → DRIVE.
- i_enable=0 in any state → OFF next cycle. Counters and idx clear; a partial frame gives no o_frame_done.
- Load path:
  - i_load=1: shadow ← i_value, pending ← 1.
  - At a frame boundary with pending=1: display ← shadow, pending ← 0.
  - The display register changes only at frame boundaries or on the OFF→DRIVE transition (which also copies shadow if pending).
  - i_load in the same cycle as a boundary: display ← i_value directly, pending ← 0.
- Decoding:
  - Nibble to segments: 0–9, A, b, C, d, E, F, standard hex glyphs.
  - The polarity parameters apply after decode.
- Segment and select update together. No cycle ever shows a new select with old segments.
- NUM_DIGITS=1: scan degenerates to DRIVE/GAP on digit 0; o_frame_done pulses every slot.

## Timing
- Slot period REFRESH_DIV+GAP_CYCLES; frame period NUM_DIGITS×(REFRESH_DIV+GAP_CYCLES).
- i_enable rising at cycle t:
  - outputs still inactive at t+1 (state registered)
  - digit 0 driven from t+2
- i_load to visible change: from the next frame boundary, or immediately at the first DRIVE after OFF.
- o_frame_done is asserted in the cycle GAP→DRIVE(idx 0) is registered, one cycle wide.
- Asynchronous reset mid-frame: outputs go inactive immediately, independent of i_clk.

## Configuration
- LEADING_ZERO_BLANK_EN
  - Defined: digit k>0 is blanked when it and every higher digit of the display register are 0. During a blanked slot o_digit_en and o_segments stay inactive, but slot timing is unchanged. Digit 0 is never blanked.
  - Undefined: all digits are always shown, including zeros.

## Structure
- Package seg7_pkg: 16-entry glyph constants (active-high, a..g ordering); state enum OFF/DRIVE/GAP; segment index constants SEG_A..SEG_G.
- Sub-module hex_to_segments: combinational nibble → 7-bit active-high glyph. Instantiated once on the selected nibble; output registered in the parent.

## Test plan
Use NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=2.
- Reset, then enable, load 0x1234 → digit 0 shows 0x33 ('4') for 4 cycles; next 2 cycles dark; digits 1–3 show 0x79, 0x6D, 0x30 in turn; o_frame_done pulses once every 24 cycles.
- Load 0xABCD mid-frame (while digit 1 is driven) → the rest of the frame still shows 0x1234; the next frame shows D, C, b, A (0x3D, 0x4E, 0x1F, 0x77).
- i_load coincident with the boundary cycle, value 0x00F0 → the following frame shows 0x00F0; pending is 0 afterwards (no repeated update).
- With LEADING_ZERO_BLANK_EN, load 0x0007 → only the digit-0 select ever asserts; frame period stays 24 cycles. Without the macro, the three zero digits show 0x7E.
- i_enable drops during digit 2 → all outputs inactive next cycle, no o_frame_done. Re-enable → scan restarts at digit 0, with outputs driven 2 cycles after re-enable.
- Assert i_rst_n low mid-DRIVE with SEG_ACTIVE_LOW=1 → o_segments=7'h7F and o_digit_en=4'hF at once, before any clock edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the multiplexed 7-segment driver:
//   - segment bit positions inside a 7-bit glyph (bit6 = a ... bit0 = g)
//   - 16-entry hex glyph table, active-high
//   - scan state enumeration
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // 0-9, A, b, C, d, E, F
  localparam logic [6:0] GLYPH_ROM [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/hex_to_segments.sv
// hex_to_segments
// Combinational nibble to active-high 7-segment glyph (bit6 = a ... bit0 = g).
// Ports:
//   nibble_i  in  4  hex digit
//   glyph_o   out 7  active-high segment pattern
module hex_to_segments
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = GLYPH_ROM[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a NUM_DIGITS common-select 7-segment display.
// Each digit is driven for REFRESH_DIV clocks, followed by GAP_CYCLES all-off
// clocks to suppress ghosting. New values are captured into a shadow register
// and moved to the display register only at frame boundaries (or when the
// scan starts from OFF), so a frame never mixes two values.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is always shown; slot timing is unchanged).
//
// Ports:
//   i_clk         in   1            clock
//   i_rst_n       in   1            asynchronous active-low reset
//   i_value       in   4*NUM_DIGITS packed nibbles, digit 0 in bits [3:0]
//   i_load        in   1            capture strobe for i_value (no handshake;
//                                   every cycle with i_load=1 is a capture)
//   i_enable      in   1            0 = display dark, scan held in OFF
//   o_segments    out  7            registered segments, bit6 = a ... bit0 = g
//   o_digit_en    out  NUM_DIGITS   registered one-hot digit select
//   o_frame_done  out  1            one-cycle pulse at each frame boundary
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 25000,
  parameter int GAP_CYCLES     = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_enable,
  output logic [6:0]              o_segments,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         DRIVE_END = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]         GAP_END   = CW'(GAP_CYCLES - 1);
  // Inactive levels; XOR with these converts active-high to pin polarity.
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  scan_state_e             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    boundary;   // GAP of last digit ends this cycle
  logic                    start;      // OFF -> DRIVE this cycle
  logic [3:0]              sel_nib;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    show;

  // Scan sequencing
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    frame_d  = 1'b0;
    boundary = 1'b0;
    start    = 1'b0;
    if (!i_enable) begin
      state_d = OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          start   = 1'b1;
        end
        DRIVE: begin
          if (cnt_q == DRIVE_END) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_END) begin
            state_d = DRIVE;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) begin
              idx_d    = '0;
              boundary = 1'b1;
              frame_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Load path: a load coinciding with a boundary bypasses the shadow so the
  // new value is not delayed by a whole frame.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    if (i_load) begin
      shadow_d  = i_value;
      pending_d = 1'b1;
    end
    if (boundary || start) begin
      if (i_load) begin
        disp_d    = i_value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_run;
  // Walk from the top digit down; a digit is blank while everything above
  // it, and itself, is zero.
  always_comb begin
    blank  = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_run   = lz_run && (disp_q[4*k +: 4] == 4'h0);
      blank[k] = lz_run;
    end
  end
`else
  assign blank = '0;
`endif

  assign sel_nib = disp_q[{idx_q, 2'b00} +: 4];
  assign onehot  = NUM_DIGITS'(1) << idx_q;

  hex_to_segments u_dec (
    .nibble_i (sel_nib),
    .glyph_o  (glyph)
  );

  // Segments and select come from the same state, so they change together.
  // Gating by i_enable darkens the outputs in the cycle after enable drops.
  assign show  = i_enable && (state_q == DRIVE) && !blank[idx_q];
  assign seg_d = show ? (glyph ^ SEG_OFF) : SEG_OFF;
  assign dig_d = show ? (onehot ^ DIG_OFF) : DIG_OFF;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      disp_q    <= '0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      frame_q   <= frame_d;
    end
  end

  assign o_segments   = seg_q;
  assign o_digit_en   = dig_q;
  assign o_frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Two instances share the stimulus: one with active-high segments, one with
// active-low segments (both with active-low digit selects). A timeline model
// predicts every registered output from the number of consecutive enabled
// cycles; predictions go through an expected queue and are compared on the
// falling edge.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int G     = 2;
  localparam int SLOT  = R + G;
  localparam int FRAME = N * SLOT;

  // ---------------- clock / reset ----------------
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic [15:0]  i_value = '0;
  logic         i_load = 1'b0;
  logic         i_enable = 1'b0;

  logic [6:0]   o_segments, al_segments;
  logic [3:0]   o_digit_en, al_digit_en;
  logic         o_frame_done, al_frame_done;

  always #5 i_clk = ~i_clk;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_value(i_value), .i_load(i_load),
    .i_enable(i_enable), .o_segments(o_segments), .o_digit_en(o_digit_en),
    .o_frame_done(o_frame_done)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_al (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_value(i_value), .i_load(i_load),
    .i_enable(i_enable), .o_segments(al_segments), .o_digit_en(al_digit_en),
    .o_frame_done(al_frame_done)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Glyphs described by their lit segment letters.
  string seg_names [16] = '{
    "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
    "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"
  };

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    logic [6:0] g;
    string s;
    g = '0;
    s = seg_names[n];
    for (int i = 0; i < s.len(); i++) g[6 - (int'(s[i]) - 97)] = 1'b1;
    return g;
  endfunction

  function automatic bit ref_blank(input logic [15:0] v, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    return (slot > 0) && ((v >> (4 * slot)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // {frame_done, digit one-hot (active-high), segments (active-high)}
  logic [11:0] exp_q[$];
  int          run;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend;

  always @(posedge i_clk or negedge i_rst_n) begin
    logic [6:0] e_seg;
    logic [3:0] e_dig;
    logic       e_frm;
    int         q, slot, off;
    if (!i_rst_n) begin
      run = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
      exp_q.delete();
    end else begin
      e_seg = '0; e_dig = '0; e_frm = 1'b0;
      if (i_enable) begin
        run++;
        // Outputs lag the scan position by one registered stage.
        if (run >= 2) begin
          q    = (run - 2) % FRAME;
          slot = q / SLOT;
          off  = q % SLOT;
          if (off < R && !ref_blank(m_disp, slot)) begin
            e_dig = 4'(1 << slot);
            e_seg = ref_glyph(m_disp[4*slot +: 4]);
          end
          if (q == FRAME - 1) e_frm = 1'b1;
        end
        // Scan start and every frame boundary may refresh the display value.
        if ((run - 1) % FRAME == 0) begin
          if (i_load) begin m_disp = i_value; m_pend = 0; end
          else if (m_pend) begin m_disp = m_shadow; m_pend = 0; end
        end else if (i_load) begin
          m_shadow = i_value; m_pend = 1;
        end
      end else begin
        run = 0;
        if (i_load) begin m_shadow = i_value; m_pend = 1; end
      end
      exp_q.push_back({e_frm, e_dig, e_seg});
    end
  end

  // ---------------- scoreboard ----------------
  int cyc = 0;
  int last_frm = -1;

  always @(negedge i_clk) begin
    logic [11:0] e;
    logic [6:0]  e_seg_n;
    logic [3:0]  e_dig_n;
    cyc++;
    if (i_rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_seg_n = ~e[6:0];
      e_dig_n = ~e[10:7];
      check("seg", o_segments, e[6:0]);
      check("dig", o_digit_en, e_dig_n);
      check("frame", o_frame_done, e[11]);
      check("seg_al", al_segments, e_seg_n);
      check("dig_al", al_digit_en, e_dig_n);
      check("frame_al", al_frame_done, e[11]);
    end
    if (!i_rst_n || !i_enable) last_frm = -1;
    else if (o_frame_done) begin
      if (last_frm >= 0) check("frame_period", cyc - last_frm, FRAME);
      last_frm = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    i_value = v;
    i_load  = 1'b1;
    tick();
    i_load  = 1'b0;
  endtask

  task automatic wait_dig(input logic [3:0] want, input string tag);
    int n = 0;
    while (o_digit_en !== want && n < 200) begin
      tick();
      n++;
    end
    check(tag, o_digit_en, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int off_left;

    // Reset values, observed before any clock edge.
    #1 i_rst_n = 1'b0;
    #2;
    check("rst_seg", o_segments, 7'h00);
    check("rst_dig", o_digit_en, 4'hF);
    check("rst_frame", o_frame_done, 1'b0);
    check("rst_seg_al", al_segments, 7'h7F);
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();

    // Load while off, then enable: value visible at first DRIVE.
    load(16'h1234);
    i_enable = 1'b1;
    tick();
    check("en_dark", o_digit_en, 4'hF);
    tick();
    check("first_seg", o_segments, 7'h33);
    check("first_dig", o_digit_en, 4'b1110);
    repeat (60) tick();

    // Mid-frame load while digit 1 is driven.
    wait_dig(4'b1101, "wait_dig1");
    load(16'hABCD);
    repeat (60) tick();

    // Enable drops during digit 2.
    wait_dig(4'b1011, "wait_dig2");
    i_enable = 1'b0;
    tick();
    check("drop_dig", o_digit_en, 4'hF);
    check("drop_seg", o_segments, 7'h00);
    check("drop_seg_al", al_segments, 7'h7F);
    check("drop_frame", o_frame_done, 1'b0);
    repeat (5) tick();
    i_enable = 1'b1;
    tick();
    check("reen_dark", o_digit_en, 4'hF);
    tick();
    check("reen_dig0", o_digit_en, 4'b1110);

    // Load coincident with a frame boundary.
    n = 0;
    while (o_frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("wait_frame", o_frame_done, 1'b1);
    repeat (FRAME - 1) tick();
    load(16'h00F0);
    check("bnd_frame", o_frame_done, 1'b1);
    repeat (60) tick();

    // Leading zeros.
    load(16'h0007);
    repeat (80) tick();

    // Randomized loads, values and enable drops.
    off_left = 0;
    for (int i = 0; i < 1500; i++) begin
      i_load  = ($urandom_range(0, 19) == 0);
      i_value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255))
                                             : 16'($urandom_range(0, 65535));
      if (off_left > 0) begin
        off_left--;
        i_enable = (off_left == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        off_left = $urandom_range(1, 5);
        i_enable = 1'b0;
      end
      tick();
    end
    i_load   = 1'b0;
    i_enable = 1'b1;
    repeat (30) tick();

    // Asynchronous reset in the middle of a DRIVE slot.
    wait_dig(4'b1110, "wait_rst");
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_seg_al", al_segments, 7'h7F);
    check("arst_dig_al", al_digit_en, 4'hF);
    check("arst_seg", o_segments, 7'h00);
    check("arst_frame", o_frame_done, 1'b0);
    tick();
    tick();
    i_rst_n = 1'b1;
    repeat (60) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
